// File: rtl/exe_stage_if.sv
// ID/EX -> EX bundle plus the EX/MEM and status outputs of the execute stage.
interface exe_stage_if;
  logic        freeze;
  logic        WB_EN_IN;
  logic        MEM_R_EN_IN;
  logic        MEM_W_EN_IN;
  logic        B_IN;
  logic        S_IN;
  logic [3:0]  EXE_CMD_IN;
  logic [31:0] PC_IN;
  logic [31:0] Val_Rn_IN;
  logic [31:0] Val_Rm_IN;
  logic        imm_IN;
  logic [11:0] Shift_operand_IN;
  logic [23:0] Signed_imm_24_IN;
  logic [3:0]  Dest_IN;

  logic        Branch_taken;
  logic [31:0] Branch_addr;
  logic [3:0]  SR;
  logic        WB_EN;
  logic        MEM_R_EN;
  logic        MEM_W_EN;
  logic [31:0] ALU_res;
  logic [31:0] Val_Rm;
  logic [3:0]  Dest;

  modport master (
    output freeze, WB_EN_IN, MEM_R_EN_IN, MEM_W_EN_IN, B_IN, S_IN, EXE_CMD_IN,
           PC_IN, Val_Rn_IN, Val_Rm_IN, imm_IN, Shift_operand_IN,
           Signed_imm_24_IN, Dest_IN,
    input  Branch_taken, Branch_addr, SR, WB_EN, MEM_R_EN, MEM_W_EN,
           ALU_res, Val_Rm, Dest
  );

  modport slave (
    input  freeze, WB_EN_IN, MEM_R_EN_IN, MEM_W_EN_IN, B_IN, S_IN, EXE_CMD_IN,
           PC_IN, Val_Rn_IN, Val_Rm_IN, imm_IN, Shift_operand_IN,
           Signed_imm_24_IN, Dest_IN,
    output Branch_taken, Branch_addr, SR, WB_EN, MEM_R_EN, MEM_W_EN,
           ALU_res, Val_Rm, Dest
  );
endinterface

// File: rtl/exe_stage.sv
// Execute stage: operand-2 shifter, ALU, NZCV status, branch target, EX/MEM register.
// EX/MEM outputs one cycle after inputs; freeze holds SR and EX/MEM, rst wins over freeze.
module exe_stage (
  input  logic        clk,
  input  logic        rst,
  exe_stage_if.slave  bus
);

  logic [3:0]  sr_q, sr_d;
  logic        wb_en_q, mem_r_en_q, mem_w_en_q;
  logic [31:0] alu_res_q, val_rm_q;
  logic [3:0]  dest_q;

  logic [31:0] val2;
  logic [4:0]  sh_imm, rot;
  logic [63:0] rm_dbl, imm_dbl;
  logic [31:0] imm8_ext;

  // Operand 2: memory offset beats rotated immediate beats shifted register
  always_comb begin
    sh_imm   = bus.Shift_operand_IN[11:7];
    rot      = {bus.Shift_operand_IN[11:8], 1'b0};
    imm8_ext = {24'b0, bus.Shift_operand_IN[7:0]};
    rm_dbl   = {bus.Val_Rm_IN, bus.Val_Rm_IN} >> sh_imm;
    imm_dbl  = {imm8_ext, imm8_ext} >> rot;
    val2     = bus.Val_Rm_IN;
    if (bus.MEM_R_EN_IN || bus.MEM_W_EN_IN) begin
      val2 = {20'b0, bus.Shift_operand_IN};
    end else if (bus.imm_IN) begin
      val2 = imm_dbl[31:0];
    end else if (sh_imm != 5'd0) begin
      case (bus.Shift_operand_IN[6:5])
        2'b00:   val2 = bus.Val_Rm_IN << sh_imm;
        2'b01:   val2 = bus.Val_Rm_IN >> sh_imm;
        2'b10:   val2 = $signed(bus.Val_Rm_IN) >>> sh_imm;
        default: val2 = rm_dbl[31:0];
      endcase
    end
  end

  logic [31:0] rn, res;
  logic [32:0] sum;
  logic        c_in, n_f, z_f, c_f, v_f;

  always_comb begin
    rn   = bus.Val_Rn_IN;
    c_in = sr_q[1];
    res  = 32'd0;
    sum  = 33'd0;
    c_f  = sr_q[1];
    v_f  = sr_q[0];
    case (bus.EXE_CMD_IN)
      4'b0001: res = val2;
      4'b1001: res = ~val2;
      4'b0010, 4'b0011: begin
        sum = {1'b0, rn} + {1'b0, val2} +
              {32'b0, (bus.EXE_CMD_IN == 4'b0011) ? c_in : 1'b0};
        res = sum[31:0];
        c_f = sum[32];
        v_f = (rn[31] == val2[31]) && (res[31] != rn[31]);
      end
      4'b0100, 4'b0101: begin
        // SUB carry is NOT borrow: Rn + ~Val2 + 1 (or + C for SBC)
        sum = {1'b0, rn} + {1'b0, ~val2} +
              {32'b0, (bus.EXE_CMD_IN == 4'b0100) ? 1'b1 : c_in};
        res = sum[31:0];
        c_f = sum[32];
        v_f = (rn[31] != val2[31]) && (res[31] != rn[31]);
      end
      4'b0110: res = rn & val2;
      4'b0111: res = rn | val2;
      4'b1000: res = rn ^ val2;
      default: res = 32'd0;
    endcase
    n_f  = res[31];
    z_f  = (res == 32'd0);
    sr_d = bus.S_IN ? {n_f, z_f, c_f, v_f} : sr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q       <= 4'd0;
      wb_en_q    <= 1'b0;
      mem_r_en_q <= 1'b0;
      mem_w_en_q <= 1'b0;
      alu_res_q  <= 32'd0;
      val_rm_q   <= 32'd0;
      dest_q     <= 4'd0;
    end else if (!bus.freeze) begin
      sr_q       <= sr_d;
      wb_en_q    <= bus.WB_EN_IN;
      mem_r_en_q <= bus.MEM_R_EN_IN;
      mem_w_en_q <= bus.MEM_W_EN_IN;
      alu_res_q  <= res;
      val_rm_q   <= bus.Val_Rm_IN;
      dest_q     <= bus.Dest_IN;
    end
  end

  assign bus.Branch_taken = bus.B_IN;
  assign bus.Branch_addr  = bus.PC_IN +
                            {{6{bus.Signed_imm_24_IN[23]}}, bus.Signed_imm_24_IN, 2'b00};
  assign bus.SR       = sr_q;
  assign bus.WB_EN    = wb_en_q;
  assign bus.MEM_R_EN = mem_r_en_q;
  assign bus.MEM_W_EN = mem_w_en_q;
  assign bus.ALU_res  = alu_res_q;
  assign bus.Val_Rm   = val_rm_q;
  assign bus.Dest     = dest_q;

endmodule

// File: tb/tb_exe_stage.sv
// Directed-vector bench for exe_stage with hand-computed expected results.
module tb_exe_stage;
  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  exe_stage_if bus ();
  exe_stage dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic [3:0] cmd, input logic s, input logic im,
                    input logic [31:0] rn, input logic [31:0] rm, input logic [11:0] sop);
    bus.EXE_CMD_IN       = cmd;
    bus.S_IN             = s;
    bus.imm_IN           = im;
    bus.Val_Rn_IN        = rn;
    bus.Val_Rm_IN        = rm;
    bus.Shift_operand_IN = sop;
    bus.MEM_R_EN_IN      = 1'b0;
    bus.MEM_W_EN_IN      = 1'b0;
    bus.WB_EN_IN         = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    bus.freeze = 1'b0;
    bus.B_IN = 1'b0;
    bus.PC_IN = 32'd0;
    bus.Signed_imm_24_IN = 24'd0;
    bus.Dest_IN = 4'd0;
    op(4'b0010, 1'b0, 1'b0, 32'h1234, 32'h5678, 12'h0);
    tick();
    check("rst_sr", {28'd0, bus.SR}, 32'h0);
    check("rst_alu", bus.ALU_res, 32'h0);
    check("rst_ctl", {29'd0, bus.WB_EN, bus.MEM_R_EN, bus.MEM_W_EN}, 32'h0);
    check("rst_valrm", bus.Val_Rm, 32'h0);
    rst = 1'b0;

    // ADDS 0xFFFFFFFF + 1 -> 0, Z and C
    op(4'b0010, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h1, 12'h000);
    bus.Dest_IN = 4'd5;
    tick();
    check("adds_res", bus.ALU_res, 32'h0);
    check("adds_sr", {28'd0, bus.SR}, 32'h6);
    check("adds_dest", {28'd0, bus.Dest}, 32'h5);

    // ADC uses the carry just written
    op(4'b0011, 1'b0, 1'b1, 32'h0, 32'h0, 12'h005);
    tick();
    check("adc_res", bus.ALU_res, 32'h6);
    check("adc_sr_kept", {28'd0, bus.SR}, 32'h6);

    op(4'b0100, 1'b1, 1'b1, 32'h8000_0000, 32'h0, 12'h001);
    tick();
    check("subs_res", bus.ALU_res, 32'h7FFF_FFFF);
    check("subs_sr", {28'd0, bus.SR}, 32'h3);

    // MOVS imm 0xFF ror 8: N set, C/V retained from SUBS
    op(4'b0001, 1'b1, 1'b1, 32'h0, 32'h0, 12'h4FF);
    tick();
    check("mov_rotimm", bus.ALU_res, 32'hFF00_0000);
    check("movs_sr", {28'd0, bus.SR}, 32'hB);

    op(4'b0001, 1'b0, 1'b0, 32'h0, 32'h8000_0000, 12'h240);
    tick();
    check("mov_asr4", bus.ALU_res, 32'hF800_0000);

    op(4'b0001, 1'b0, 1'b0, 32'h0, 32'h0000_00AB, 12'h460);
    tick();
    check("mov_ror8", bus.ALU_res, 32'hAB00_0000);

    op(4'b0001, 1'b0, 1'b0, 32'h0, 32'h1234_5678, 12'h060);
    tick();
    check("ror0_pass", bus.ALU_res, 32'h1234_5678);

    op(4'b0001, 1'b0, 1'b0, 32'h0, 32'h0000_000F, 12'h200);
    tick();
    check("mov_lsl4", bus.ALU_res, 32'h0000_00F0);

    op(4'b0001, 1'b0, 1'b0, 32'h0, 32'h0000_00F0, 12'h220);
    tick();
    check("mov_lsr4", bus.ALU_res, 32'h0000_000F);

    // LDR: memory offset wins over imm
    op(4'b0010, 1'b0, 1'b1, 32'h100, 32'hDEAD_BEEF, 12'h004);
    bus.MEM_R_EN_IN = 1'b1;
    bus.Dest_IN = 4'd9;
    tick();
    check("ldr_addr", bus.ALU_res, 32'h104);
    check("ldr_ctl", {29'd0, bus.WB_EN, bus.MEM_R_EN, bus.MEM_W_EN}, 32'h6);
    check("ldr_sr", {28'd0, bus.SR}, 32'hB);
    check("ldr_valrm", bus.Val_Rm, 32'hDEAD_BEEF);

    op(4'b0101, 1'b1, 1'b1, 32'h5, 32'h0, 12'h003);
    tick();
    check("sbcs_res", bus.ALU_res, 32'h2);
    check("sbcs_sr", {28'd0, bus.SR}, 32'h2);

    op(4'b0010, 1'b1, 1'b1, 32'h7FFF_FFFF, 32'h0, 12'h001);
    tick();
    check("adds_ovf_res", bus.ALU_res, 32'h8000_0000);
    check("adds_ovf_sr", {28'd0, bus.SR}, 32'h9);

    op(4'b0000, 1'b1, 1'b0, 32'h1111_1111, 32'h2222_2222, 12'h000);
    tick();
    check("badcmd_res", bus.ALU_res, 32'h0);
    check("badcmd_sr", {28'd0, bus.SR}, 32'h5);

    op(4'b1000, 1'b1, 1'b0, 32'hFF00_FF00, 32'h0F0F_0F0F, 12'h000);
    tick();
    check("eors_res", bus.ALU_res, 32'hF00F_F00F);
    check("eors_sr", {28'd0, bus.SR}, 32'h9);

    op(4'b1001, 1'b0, 1'b1, 32'h0, 32'hCAFE_0001, 12'h000);
    bus.Dest_IN = 4'd3;
    tick();
    check("mvn_res", bus.ALU_res, 32'hFFFF_FFFF);

    // Branch outputs are combinational
    bus.B_IN = 1'b1;
    bus.PC_IN = 32'h40;
    bus.Signed_imm_24_IN = 24'hFFFFFE;
    #1;
    check("br_taken", {31'd0, bus.Branch_taken}, 32'h1);
    check("br_addr", bus.Branch_addr, 32'h38);
    bus.Signed_imm_24_IN = 24'h000004;
    #1;
    check("br_fwd", bus.Branch_addr, 32'h50);
    bus.B_IN = 1'b0;

    // Freeze holds EX/MEM and SR for two edges
    bus.freeze = 1'b1;
    op(4'b0010, 1'b1, 1'b0, 32'h0, 32'h0, 12'h000);
    bus.Dest_IN = 4'd7;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("frz_res", bus.ALU_res, 32'hFFFF_FFFF);
      check("frz_sr", {28'd0, bus.SR}, 32'h9);
      check("frz_dest", {28'd0, bus.Dest}, 32'h3);
    end
    bus.freeze = 1'b0;
    tick();
    check("unfrz_res", bus.ALU_res, 32'h0);
    check("unfrz_sr", {28'd0, bus.SR}, 32'h4);
    check("unfrz_dest", {28'd0, bus.Dest}, 32'h7);

    // Reset overrides freeze
    op(4'b0001, 1'b1, 1'b1, 32'h0, 32'h0, 12'h0FF);
    tick();
    bus.freeze = 1'b1;
    rst = 1'b1;
    tick();
    check("rstfrz_sr", {28'd0, bus.SR}, 32'h0);
    check("rstfrz_res", bus.ALU_res, 32'h0);
    check("rstfrz_wb", {31'd0, bus.WB_EN}, 32'h0);
    rst = 1'b0;
    bus.freeze = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
